arbitro_memoria_dados: RTL and testbench

Two-port round-robin arbiter and access sequencer for the single-port data memory (`memoria_de_dados`). It shares the memory between port 0 (CPU load/store stage) and port 1 (I/O / DMA engine). It drives the memory's `we`, `addr` and `datain`, and returns registered read data with a one-cycle acknowledge per transaction. It also blocks out-of-range accesses.

---
 rtl/arbitro_memoria_dados.sv | 131 +++++++++++++
 tb/tb_arbitro_memoria_dados.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: round-robin arbiter and access sequencer that
// shares one single-port data memory between port 0 (CPU) and port 1 (DMA).
// Ports: clk, rst (sync, active-high);
//   per port N: reqN/weN/addrN/wdataN in, ackN/errN/rdataN out;
//   memory: mem_we/mem_addr/mem_datain out, mem_dataout in.
module arbitro_memoria_dados #(
  parameter int unsigned RAM_SIZE = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [31:0] LIMIT = 32'(RAM_SIZE);

  logic [1:0]  r_state;
  logic        r_last;
  logic        r_sel;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_err0;
  logic        r_err1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_any;
  logic        w_win;
  logic        w_inrange;
  logic        w_access;
  logic [31:0] w_rd;

  assign w_any = req0 | req1;

  // On a tie the port that was not served last wins.
  assign w_win = (req0 & req1) ? ~r_last : req1;

  assign w_inrange = (r_addr < LIMIT);
  assign w_access  = (r_state == ACCESS);

  // Writes and out-of-range reads return zero.
  assign w_rd = (r_we | ~w_inrange) ? 32'd0 : mem_dataout;

  // rst gates the strobe so a reset in ACCESS never commits a write.
  assign mem_we     = w_access & r_we & w_inrange & ~rst;
  assign mem_addr   = r_addr;
  assign mem_datain = r_wdata;

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign err0   = r_err0;
  assign err1   = r_err1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_win;
            r_we    <= w_win ? we1 : we0;
            r_addr  <= w_win ? addr1 : addr0;
            r_wdata <= w_win ? wdata1 : wdata0;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_sel) begin
            r_rdata1 <= w_rd;
            r_ack1   <= 1'b1;
            r_err1   <= ~w_inrange;
          end else begin
            r_rdata0 <= w_rd;
            r_ack0   <= 1'b1;
            r_err0   <= ~w_inrange;
          end
          r_last  <= r_sel;
          r_state <= RESP;
        end
        RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// tb_arbitro_memoria_dados: bench for the two-port data memory arbiter,
// with a behavioural memory and a shadow copy used as reference.
module tb_arbitro_memoria_dados;

  localparam int RAM = 150;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_datain, mem_dataout;

  logic [31:0] mem   [RAM];
  logic [31:0] ref_m [RAM];
  logic        init_mem = 1'b1;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt;

  arbitro_memoria_dados #(.RAM_SIZE(RAM)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0),
    .wdata0(wdata0), .ack0(ack0), .err0(err0),
    .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1),
    .wdata1(wdata1), .ack1(ack1), .err1(err1),
    .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_datain(mem_datain),
    .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] seedv(int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010F03);
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < RAM; i++) mem[i] <= seedv(i);
    end else if (mem_we && mem_addr < 32'd150) begin
      mem[mem_addr[7:0]] <= mem_datain;
    end
  end

  // Non-zero filler for unmapped addresses exposes a missing range check.
  assign mem_dataout = (mem_addr < 32'd150) ?
                       mem[mem_addr[7:0]] : 32'h0BAD0BAD;

  function automatic logic [31:0] exp_rd(logic w, logic [31:0] a);
    if (w || a >= 32'd150) return 32'd0;
    return ref_m[a[7:0]];
  endfunction

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Raise a request and wait (bounded) for its ack; req drops in
  // the ack cycle. lat counts cycles from the request to the ack.
  task automatic txn(input int p, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd,
                     output logic er, output logic ok);
    int t0;
    t0 = cyc;
    rd = '0;
    er = 1'b0;
    ok = 1'b0;
    drive(p, 1'b1, w, a, d);
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk);
      if ((p == 0) ? ack0 : ack1) begin
        ok = 1'b1;
        rd = (p == 0) ? rdata0 : rdata1;
        er = (p == 0) ? err0 : err1;
      end
    end
    lat = cyc - t0;
    drive(p, 1'b0, w, a, d);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_mem = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({ack0, ack1, err0, err1, mem_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000",
               {ack0, ack1, err0, err1, mem_we});
    end
    n_vec++;
    if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h %h want 0 0", rdata0, rdata1);
    end
    n_vec++;
    if (mem_addr !== 32'd0 || mem_datain !== 32'd0) begin
      n_err++;
      $display("FAIL reset_latch: got %h %h want 0 0",
               mem_addr, mem_datain);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    init_mem = 1'b0;
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] rd;
    logic er, ok;
    @(posedge clk);
    #1 drive(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    @(negedge clk);
    n_vec++;
    if (mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL wr_idle_we: got %b want 0", mem_we);
    end
    @(negedge clk);
    n_vec++;
    if (mem_we !== 1'b1 || mem_addr !== 32'd5 ||
        mem_datain !== 32'hDEADBEEF || ack0 !== 1'b0) begin
      n_err++;
      $display("FAIL wr_access: got we=%b a=%h d=%h ack=%b want 1 5 deadbeef 0",
               mem_we, mem_addr, mem_datain, ack0);
    end
    @(negedge clk);
    n_vec++;
    if (ack0 !== 1'b1 || err0 !== 1'b0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL wr_ack: got ack=%b err=%b we=%b want 1 0 0",
               ack0, err0, mem_we);
    end
    drive(0, 1'b0, 1'b0, 32'd5, 32'd0);
    ref_m[5] = 32'hDEADBEEF;
    @(negedge clk);
    n_vec++;
    if (ack0 !== 1'b0) begin
      n_err++;
      $display("FAIL wr_ack_pulse: got %b want 0", ack0);
    end
    txn(0, 1'b0, 32'd5, 32'd0, lat, rd, er, ok);
    n_vec++;
    if (!ok || lat != 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_err++;
      $display("FAIL rd5: got ok=%b lat=%0d rd=%h err=%b want 1 2 deadbeef 0",
               ok, lat, rd, er);
    end
  endtask

  task automatic test_tie();
    int nack, prev, p;
    logic [31:0] a;
    apply_reset();
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 32'd10, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd20, 32'd0);
    nack = 0;
    prev = 0;
    for (int k = 0; k < 20 && nack < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (ack0 && ack1) begin
        n_err++;
        $display("FAIL tie_overlap: got both acks want one");
      end
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        a = (p == 0) ? 32'd10 : 32'd20;
        n_vec++;
        if (p != nack % 2) begin
          n_err++;
          $display("FAIL tie_order: ack %0d got port %0d want %0d",
                   nack, p, nack % 2);
        end
        n_vec++;
        if (((p == 0) ? rdata0 : rdata1) !== ref_m[a[7:0]]) begin
          n_err++;
          $display("FAIL tie_rdata: got %h want %h",
                   (p == 0) ? rdata0 : rdata1, ref_m[a[7:0]]);
        end
        if (nack > 0) begin
          n_vec++;
          if (cyc - prev != 3) begin
            n_err++;
            $display("FAIL tie_spacing: got %0d want 3", cyc - prev);
          end
        end
        prev = cyc;
        nack++;
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    n_vec++;
    if (nack != 4) begin
      n_err++;
      $display("FAIL tie_count: got %0d acks want 4", nack);
    end
  endtask

  task automatic test_held();
    int nack, first;
    @(posedge clk);
    #1 drive(0, 1'b1, 1'b0, 32'd33, 32'd0);
    nack = 0;
    first = 0;
    for (int k = 0; k < 14 && nack < 2; k++) begin
      @(negedge clk);
      if (ack0) begin
        n_vec++;
        if (rdata0 !== ref_m[33]) begin
          n_err++;
          $display("FAIL held_rdata: got %h want %h", rdata0, ref_m[33]);
        end
        if (nack == 1) begin
          n_vec++;
          if (cyc - first != 3) begin
            n_err++;
            $display("FAIL held_spacing: got %0d want 3", cyc - first);
          end
        end
        first = cyc;
        nack++;
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    n_vec++;
    if (nack != 2) begin
      n_err++;
      $display("FAIL held_count: got %0d acks want 2", nack);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [31:0] rd;
    logic er, ok;
    @(posedge clk);
    #1 drive(1, 1'b1, 1'b1, 32'd150, 32'h1234);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL oor_we: cycle %0d got %b want 0", k, mem_we);
      end
    end
    n_vec++;
    if (ack1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'd0) begin
      n_err++;
      $display("FAIL oor_wr_ack: got ack=%b err=%b rd=%h want 1 1 0",
               ack1, err1, rdata1);
    end
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    txn(1, 1'b0, 32'd149, 32'd0, lat, rd, er, ok);
    n_vec++;
    if (!ok || rd !== ref_m[149] || er !== 1'b0) begin
      n_err++;
      $display("FAIL oor_word149: got ok=%b rd=%h err=%b want 1 %h 0",
               ok, rd, er, ref_m[149]);
    end
    txn(1, 1'b0, 32'hFFFFFFFF, 32'd0, lat, rd, er, ok);
    n_vec++;
    if (!ok || rd !== 32'd0 || er !== 1'b1) begin
      n_err++;
      $display("FAIL oor_rd_max: got ok=%b rd=%h err=%b want 1 0 1",
               ok, rd, er);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [31:0] rd;
    logic er, ok;
    txn(0, 1'b0, 32'd5, 32'd0, lat, rd, er, ok);
    @(posedge clk);
    #1 drive(0, 1'b1, 1'b1, 32'd7, 32'h0000AAAA);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL rstw_we: got %b want 0", mem_we);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_vec++;
    if ({ack0, err0, ack1, err1, mem_we} !== 5'b0 ||
        rdata0 !== 32'd0 || mem_addr !== 32'd0 ||
        mem_datain !== 32'd0) begin
      n_err++;
      $display("FAIL rstw_outputs: got %b rd=%h a=%h d=%h want 00000 0 0 0",
               {ack0, err0, ack1, err1, mem_we},
               rdata0, mem_addr, mem_datain);
    end
    txn(0, 1'b0, 32'd7, 32'd0, lat, rd, er, ok);
    n_vec++;
    if (!ok || rd !== ref_m[7] || er !== 1'b0) begin
      n_err++;
      $display("FAIL rstw_word7: got ok=%b rd=%h err=%b want 1 %h 0",
               ok, rd, er, ref_m[7]);
    end
  endtask

  task automatic test_starvation();
    logic stop;
    stop = 1'b0;
    fork
      begin
        int lat;
        logic [31:0] rd, a;
        logic er, ok;
        while (!stop) begin
          a = $urandom_range(0, RAM - 1);
          txn(0, 1'b0, a, 32'd0, lat, rd, er, ok);
          n_vec++;
          if (!ok || rd !== exp_rd(1'b0, a)) begin
            n_err++;
            $display("FAIL starve_p0: got ok=%b rd=%h want 1 %h",
                     ok, rd, exp_rd(1'b0, a));
          end
        end
      end
      begin
        int lat;
        logic [31:0] rd, a;
        logic er, ok;
        for (int r = 0; r < 5; r++) begin
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1;
          a = $urandom_range(0, RAM - 1);
          txn(1, 1'b0, a, 32'd0, lat, rd, er, ok);
          n_vec++;
          if (!ok || lat > 6 || rd !== exp_rd(1'b0, a)) begin
            n_err++;
            $display("FAIL starve_p1: got ok=%b lat=%0d rd=%h want 1 <=6 %h",
                     ok, lat, rd, exp_rd(1'b0, a));
          end
        end
        stop = 1'b1;
      end
    join
  endtask

  task automatic worker(input int p, input int n);
    int lat;
    logic [31:0] rd, a, d, e;
    logic er, ok, w;
    int sel;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      sel = $urandom_range(0, 9);
      if (sel == 0) a = $urandom_range(150, 400);
      else if (sel == 1) a = 32'hFFFFFFFF - $urandom_range(0, 3);
      else a = $urandom_range(0, RAM - 1);
      w = $urandom_range(0, 1);
      d = $urandom;
      txn(p, w, a, d, lat, rd, er, ok);
      e = exp_rd(w, a);
      n_vec++;
      if (!ok || lat > 6 || rd !== e || er !== (a >= 32'd150)) begin
        n_err++;
        $display("FAIL rand_p%0d: a=%h w=%b got ok=%b lat=%0d rd=%h err=%b want 1 <=6 %h %b",
                 p, a, w, ok, lat, rd, er, e, a >= 32'd150);
      end
      if (w && a < 32'd150) ref_m[a[7:0]] = d;
    end
    done_cnt++;
  endtask

  task automatic test_random();
    done_cnt = 0;
    fork
      worker(0, 15);
      worker(1, 15);
      while (done_cnt < 2) begin
        @(negedge clk);
        n_vec++;
        if (ack0 && ack1) begin
          n_err++;
          $display("FAIL rand_overlap: got both acks want one");
        end
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < RAM; i++) ref_m[i] = seedv(i);
    test_reset();
    test_write_read();
    test_tie();
    test_held();
    test_out_of_range();
    test_reset_mid_write();
    test_starvation();
    test_random();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
